// File: rtl/led_pwm_multi.sv
// Multi-channel status-LED PWM driver with per-channel direct, peak-hold decay,
// blink and off modes. Shared prescaled PWM, fade and blink timebases.
module led_pwm_multi #(
   parameter int CHANNELS      = 4,
   parameter int LEVEL_BITS    = 6,
   parameter int PRESCALE      = 100,
   parameter int FADE_PERIODS  = 64,
   parameter int BLINK_PERIODS = 256
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [CHANNELS*LEVEL_BITS-1:0] level,
   input  logic [CHANNELS*2-1:0]          mode,
   output logic [CHANNELS-1:0]            leds_out
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int FW = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
   localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [FW-1:0] FADE_MAX  = FW'(FADE_PERIODS - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_PERIODS - 1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [LEVEL_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [FW-1:0]         fade_cnt_q, fade_cnt_d;
   logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic                  tick, ps, fade_step;

   always_comb begin
      tick          = (presc_q == PRESC_MAX);
      ps            = tick && (&pwm_cnt_q);
      fade_step     = ps && (fade_cnt_q == FADE_MAX);
      presc_d       = tick ? '0 : presc_q + 1'b1;
      pwm_cnt_d     = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
      fade_cnt_d    = fade_cnt_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (ps) begin
         fade_cnt_d = (fade_cnt_q == FADE_MAX) ? '0 : fade_cnt_q + 1'b1;
         if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q       <= '0;
         pwm_cnt_q     <= '0;
         fade_cnt_q    <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
      end else begin
         presc_q       <= presc_d;
         pwm_cnt_q     <= pwm_cnt_d;
         fade_cnt_q    <= fade_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [LEVEL_BITS-1:0] lvl;
         logic [1:0]            md;
         logic [LEVEL_BITS-1:0] eff_q, eff_d;
         logic                  led_q, led_d;

         assign lvl = level[gi*LEVEL_BITS +: LEVEL_BITS];
         assign md  = mode[2*gi +: 2];

         // Effective brightness only moves at period start so a period's duty never glitches.
         always_comb begin
            eff_d = eff_q;
            if (ps) begin
               case (md)
                  2'b00: eff_d = lvl;
                  2'b01: begin
                     if (lvl > eff_q)
                        eff_d = lvl;
                     else if (fade_step && (eff_q != '0))
                        eff_d = eff_q - 1'b1;
                  end
                  2'b10: eff_d = blink_phase_q ? lvl : '0;
                  default: eff_d = '0;
               endcase
            end
            led_d = (pwm_cnt_d < eff_d);
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               eff_q <= '0;
               led_q <= 1'b0;
            end else begin
               eff_q <= eff_d;
               led_q <= led_d;
            end
         end

         assign leds_out[gi] = led_q;
      end
   endgenerate
endmodule
